// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one ALU among N requesters.
// One operation is in flight at a time; results and flags are registered on completion.
module alu_arbiter #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int OPW      = 6,
    parameter int MAX_WAIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*OPW-1:0]     req_opcode,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         done,
    output logic                 err,
    output logic [W-1:0]         res_acc1,
    output logic [W-1:0]         res_acc2,
    output logic [3:0]           res_flags,
    output logic [$clog2(N)-1:0] res_id,
    output logic                 busy,
    output logic                 alu_bgn,
    output logic [OPW-1:0]       alu_opcode,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    input  logic [W-1:0]         alu_acc1,
    input  logic [W-1:0]         alu_acc2,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_carry,
    input  logic                 alu_overflow,
    input  logic                 alu_rdy
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] owner_q;
    logic [CW-1:0]  cnt_q;
    logic           err_q;
    logic [OPW-1:0] opcode_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   acc1_q, acc2_q;
    logic [3:0]     flags_q;
    logic [IDW-1:0] res_id_q;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           any_req;
    logic           timeout;
    logic           capture;

    // First asserted request at or after ptr, wrapping past N-1.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IDW'((32'(ptr_q) + i) % N);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    assign timeout = (cnt_q == CW'(MAX_WAIT));
    assign capture = (state_q == S_WAIT) && alu_rdy;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Illegal opcodes still pass through ISSUE (without alu_bgn) so gnt and done never coincide.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = err_q ? S_RESP : S_ARM;
            S_ARM: begin
                if (timeout)       state_d = S_RESP;
                else if (!alu_rdy) state_d = S_WAIT;
            end
            S_WAIT:  if (alu_rdy || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt     = '0;
        done    = '0;
        err     = 1'b0;
        alu_bgn = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_ISSUE: begin
                gnt[owner_q] = 1'b1;
                alu_bgn      = !err_q;
            end
            S_RESP: begin
                done[owner_q] = 1'b1;
                err           = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc1_q   <= '0;
            acc2_q   <= '0;
            flags_q  <= '0;
            res_id_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q  <= sel;
                        opcode_q <= req_opcode[sel*OPW +: OPW];
                        a_q      <= req_a[sel*W +: W];
                        b_q      <= req_b[sel*W +: W];
                        err_q    <= (req_opcode[sel*OPW +: OPW] == '0);
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_ARM, S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (state_d == S_RESP && !capture) err_q <= 1'b1;
                end
                S_RESP: ptr_q <= (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
                default: ;
            endcase
            if (capture) begin
                acc1_q  <= alu_acc1;
                acc2_q  <= alu_acc2;
                flags_q <= {alu_zero, alu_negative, alu_carry, alu_overflow};
            end
            if (state_d == S_RESP && state_q != S_RESP) res_id_q <= owner_q;
        end
    end

    assign res_acc1   = acc1_q;
    assign res_acc2   = acc2_q;
    assign res_flags  = flags_q;
    assign res_id     = res_id_q;
    assign alu_opcode = opcode_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU responder plus a scoreboard of expected completions.
module tb_alu_arbiter;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int OPW = 6;
    localparam int MW  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*OPW-1:0] req_opcode = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     gnt, done;
    logic             err, busy, alu_bgn;
    logic [W-1:0]     res_acc1, res_acc2, alu_a, alu_b;
    logic [3:0]       res_flags;
    logic [1:0]       res_id;
    logic [OPW-1:0]   alu_opcode;
    logic [W-1:0]     alu_acc1 = '0;
    logic [W-1:0]     alu_acc2 = '0;
    logic             alu_zero = 1'b0, alu_negative = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;
    logic             alu_rdy = 1'b0;

    alu_arbiter #(.N(N), .W(W), .OPW(OPW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .err(err), .res_acc1(res_acc1), .res_acc2(res_acc2),
        .res_flags(res_flags), .res_id(res_id), .busy(busy), .alu_bgn(alu_bgn),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_acc1(alu_acc1),
        .alu_acc2(alu_acc2), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_rdy(alu_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ALU behaviour: acc1 = A+B, acc2 = A-B, flags {zero, negative, carry, overflow} of the sum.
    function automatic logic [35:0] alu_fn(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] d;
        logic        v;
        s = {1'b0, a} + {1'b0, b};
        d = a - b;
        v = (a[15] == b[15]) && (s[15] != a[15]);
        return {s[15:0], d, (s[15:0] == 16'h0), s[15], s[16], v};
    endfunction

    typedef enum int {M_NORMAL, M_STALE, M_NEVER, M_STUCK} mode_t;
    mode_t       mode = M_NORMAL;
    int          age = 0;
    logic [15:0] lat_a = '0, lat_b = '0;

    always @(negedge clk) begin
        if (alu_bgn === 1'b1) begin
            age   <= 1;
            lat_a <= alu_a;
            lat_b <= alu_b;
            if (mode == M_STALE || mode == M_STUCK) begin
                alu_rdy  <= 1'b1;
                alu_acc1 <= 16'hDEAD;
                alu_acc2 <= 16'hBEEF;
                {alu_zero, alu_negative, alu_carry, alu_overflow} <= 4'b1111;
            end
        end else if (age > 0) begin
            age <= age + 1;
            case (mode)
                M_NORMAL: begin
                    if (age == 1) alu_rdy <= 1'b0;
                    if (age == 2) begin
                        alu_rdy <= 1'b1;
                        {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} <= alu_fn(lat_a, lat_b);
                    end
                end
                M_STALE: begin
                    if (age == 4) alu_rdy <= 1'b0;
                    if (age == 5) begin
                        alu_rdy <= 1'b1;
                        {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} <= alu_fn(lat_a, lat_b);
                    end
                end
                M_NEVER: alu_rdy <= 1'b0;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [1:0]  id;
        logic [15:0] acc1;
        logic [15:0] acc2;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_acc1 = '0, last_acc2 = '0;
    logic [3:0]  last_flags = '0;

    task automatic push_exp(input int id, input logic [15:0] a, input logic [15:0] b, input bit bad);
        exp_t        e;
        logic [35:0] r;
        e.id  = 2'(id);
        e.err = bad;
        if (bad) begin
            e.acc1 = last_acc1; e.acc2 = last_acc2; e.flags = last_flags;
        end else begin
            r = alu_fn(a, b);
            e.acc1 = r[35:20]; e.acc2 = r[19:4]; e.flags = r[3:0];
            last_acc1 = e.acc1; last_acc2 = e.acc2; last_flags = e.flags;
        end
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        req_opcode[id*OPW +: OPW] = op;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req[id] = 1'b1;
    endtask

    logic [N-1:0] r_gnt;
    int           r_gnt_cyc, r_bgn_cnt, r_bgn_cyc, r_done_cyc;
    bit           r_seen;

    // Steps until a done pulse (or the budget runs out), recording grant/issue/done timing.
    task automatic step_until_done(input int budget);
        r_seen = 0; r_gnt = '0; r_bgn_cnt = 0; r_gnt_cyc = -1; r_bgn_cyc = -1; r_done_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt !== '0 && r_gnt === '0) begin
                r_gnt = gnt; r_gnt_cyc = cyc; req = req & ~gnt;
            end
            if (alu_bgn === 1'b1) begin r_bgn_cnt++; r_bgn_cyc = cyc; end
            if (done !== '0) begin r_seen = 1; r_done_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0;
        @(negedge clk); @(negedge clk);
        checks++; if ({gnt, done, err, busy, alu_bgn} !== '0) begin errors++;
            $display("FAIL reset_ctrl: got=%b want=0", {gnt, done, err, busy, alu_bgn}); end
        checks++; if ({res_acc1, res_acc2, res_flags, res_id} !== '0) begin errors++;
            $display("FAIL reset_res: got=%h want=0", {res_acc1, res_acc2, res_flags, res_id}); end
        checks++; if ({alu_opcode, alu_a, alu_b} !== '0) begin errors++;
            $display("FAIL reset_alu: got=%h want=0", {alu_opcode, alu_a, alu_b}); end
        rst = 1'b0;
        last_acc1 = '0; last_acc2 = '0; last_flags = '0;
    endtask

    task automatic test_single();
        exp_t e;
        mode = M_NORMAL;
        set_req(2, 6'd1, 16'd5, 16'd7);
        push_exp(2, 16'd5, 16'd7, 0);
        step_until_done(30);
        checks++; if (!r_seen) begin errors++; $display("FAIL single_done_seen: got=0 want=1"); end
        checks++; if (r_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got=%b want=0100", r_gnt); end
        checks++; if (r_bgn_cnt != 1 || r_bgn_cyc != r_gnt_cyc) begin errors++;
            $display("FAIL single_bgn: got=%0d pulses at %0d want=1 at %0d", r_bgn_cnt, r_bgn_cyc, r_gnt_cyc); end
        checks++; if (r_done_cyc - r_gnt_cyc != 3) begin errors++;
            $display("FAIL single_latency: got=%0d want=3", r_done_cyc - r_gnt_cyc); end
        e = sb.pop_front();
        checks++; if (done !== 4'(1 << e.id) || res_id !== e.id) begin errors++;
            $display("FAIL single_owner: got done=%b id=%0d want id=%0d", done, res_id, e.id); end
        checks++; if (res_acc1 !== e.acc1 || res_acc2 !== e.acc2) begin errors++;
            $display("FAIL single_acc: got=%h/%h want=%h/%h", res_acc1, res_acc2, e.acc1, e.acc2); end
        checks++; if (err !== e.err || res_flags !== e.flags) begin errors++;
            $display("FAIL single_flags: got err=%b fl=%b want err=%b fl=%b", err, res_flags, e.err, e.flags); end
        checks++; if (alu_opcode !== 6'd1) begin errors++; $display("FAIL single_opcode: got=%0d want=1", alu_opcode); end
    endtask

    task automatic test_stale_rdy();
        exp_t e;
        mode = M_STALE;
        set_req(1, 6'd5, 16'h1234, 16'h0F0F);
        push_exp(1, 16'h1234, 16'h0F0F, 0);
        step_until_done(40);
        checks++; if (!r_seen || r_done_cyc - r_bgn_cyc != 6) begin errors++;
            $display("FAIL stale_timing: got seen=%0b dist=%0d want 1/6", r_seen, r_done_cyc - r_bgn_cyc); end
        e = sb.pop_front();
        checks++; if (done !== 4'(1 << e.id) || err !== e.err) begin errors++;
            $display("FAIL stale_done: got=%b err=%b want=%b err=%b", done, err, 4'(1 << e.id), e.err); end
        checks++; if (res_acc1 !== e.acc1 || res_acc2 !== e.acc2 || res_flags !== e.flags) begin errors++;
            $display("FAIL stale_capture: got=%h/%h/%b want=%h/%h/%b", res_acc1, res_acc2, res_flags, e.acc1, e.acc2, e.flags); end
        checks++; if (alu_opcode !== 6'd5) begin errors++; $display("FAIL stale_opcode: got=%0d want=5", alu_opcode); end
    endtask

    task automatic test_timeout();
        exp_t e;
        mode = M_NEVER;
        set_req(0, 6'd1, 16'h0101, 16'h0202);
        push_exp(0, 16'h0101, 16'h0202, 1);
        step_until_done(40);
        checks++; if (!r_seen || r_done_cyc - r_bgn_cyc != MW + 2) begin errors++;
            $display("FAIL timeout_wait_dist: got seen=%0b dist=%0d want 1/%0d", r_seen, r_done_cyc - r_bgn_cyc, MW + 2); end
        e = sb.pop_front();
        checks++; if (done !== 4'(1 << e.id) || err !== 1'b1) begin errors++;
            $display("FAIL timeout_wait_err: got=%b err=%b want=%b err=1", done, err, 4'(1 << e.id)); end
        checks++; if (res_acc1 !== e.acc1 || res_acc2 !== e.acc2 || res_flags !== e.flags) begin errors++;
            $display("FAIL timeout_hold: got=%h/%h/%b want=%h/%h/%b", res_acc1, res_acc2, res_flags, e.acc1, e.acc2, e.flags); end

        mode = M_STUCK;
        set_req(3, 6'd2, 16'h0003, 16'h0004);
        push_exp(3, 16'h0003, 16'h0004, 1);
        step_until_done(40);
        e = sb.pop_front();
        checks++; if (!r_seen || r_done_cyc - r_bgn_cyc != MW + 2) begin errors++;
            $display("FAIL timeout_arm_dist: got seen=%0b dist=%0d want 1/%0d", r_seen, r_done_cyc - r_bgn_cyc, MW + 2); end
        checks++; if (done !== 4'(1 << e.id) || err !== 1'b1 || res_acc1 !== e.acc1) begin errors++;
            $display("FAIL timeout_arm_err: got=%b err=%b acc=%h want=%b err=1 acc=%h", done, err, res_acc1, 4'(1 << e.id), e.acc1); end

        mode = M_NORMAL;
        set_req(1, 6'd1, 16'h00F0, 16'h000F);
        push_exp(1, 16'h00F0, 16'h000F, 0);
        step_until_done(30);
        e = sb.pop_front();
        checks++; if (!r_seen || done !== 4'(1 << e.id) || err !== 1'b0) begin errors++;
            $display("FAIL timeout_recover: got seen=%0b done=%b err=%b want done=%b err=0", r_seen, done, err, 4'(1 << e.id)); end
        checks++; if (res_acc1 !== e.acc1 || res_acc2 !== e.acc2) begin errors++;
            $display("FAIL timeout_recover_acc: got=%h/%h want=%h/%h", res_acc1, res_acc2, e.acc1, e.acc2); end
    endtask

    task automatic test_illegal();
        exp_t e;
        mode = M_NORMAL;
        set_req(1, 6'd0, 16'h5555, 16'h1111);
        push_exp(1, 16'h5555, 16'h1111, 1);
        step_until_done(20);
        checks++; if (r_gnt !== 4'b0010 || !r_seen || r_done_cyc - r_gnt_cyc != 1) begin errors++;
            $display("FAIL illegal_timing: got gnt=%b dist=%0d want 0010/1", r_gnt, r_done_cyc - r_gnt_cyc); end
        checks++; if (r_bgn_cnt != 0) begin errors++; $display("FAIL illegal_bgn: got=%0d want=0", r_bgn_cnt); end
        e = sb.pop_front();
        checks++; if (done !== 4'(1 << e.id) || err !== 1'b1 || res_acc1 !== e.acc1 || res_flags !== e.flags) begin errors++;
            $display("FAIL illegal_resp: got=%b err=%b acc=%h want=%b err=1 acc=%h", done, err, res_acc1, 4'(1 << e.id), e.acc1); end

        // pointer now at 2: among {0,1,3} requester 3 wins
        set_req(0, 6'd1, 16'h0010, 16'h0001);
        set_req(1, 6'd1, 16'h0020, 16'h0002);
        set_req(3, 6'd1, 16'h0030, 16'h0003);
        push_exp(3, 16'h0030, 16'h0003, 0);
        step_until_done(30);
        req = '0;
        e = sb.pop_front();
        checks++; if (r_gnt !== 4'b1000) begin errors++; $display("FAIL illegal_ptr: got=%b want=1000", r_gnt); end
        checks++; if (done !== 4'(1 << e.id) || res_acc1 !== e.acc1) begin errors++;
            $display("FAIL illegal_next: got=%b acc=%h want=%b acc=%h", done, res_acc1, 4'(1 << e.id), e.acc1); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          order[6] = '{0, 1, 2, 3, 0, 1};
        logic [15:0] opa[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] opb[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h8000};
        int          ng = 0, nd = 0, prev_done = -1, prev_bgn = -1;
        mode = M_NORMAL;
        for (int i = 0; i < N; i++) set_req(i, 6'd1, opa[i], opb[i]);
        for (int k = 0; k < 6; k++) push_exp(order[k], opa[order[k]], opb[order[k]], 0);
        for (int c = 0; c < 200 && nd < 6; c++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                checks++; if (ng >= 6 || gnt !== 4'(1 << order[ng])) begin errors++;
                    $display("FAIL rr_order[%0d]: got=%b want=%b", ng, gnt, (ng < 6) ? 4'(1 << order[ng]) : 4'b0); end
                if (prev_done >= 0) begin
                    checks++; if (cyc - prev_done != 2) begin errors++;
                        $display("FAIL rr_gap: got=%0d want=2", cyc - prev_done); end
                end
                ng++;
                if (ng == 6) req = '0;
            end
            if (alu_bgn === 1'b1) begin
                if (prev_bgn >= 0) begin
                    checks++; if (cyc - prev_bgn != 5) begin errors++;
                        $display("FAIL rr_bgn_spacing: got=%0d want=5", cyc - prev_bgn); end
                end
                prev_bgn = cyc;
            end
            if (done !== '0) begin
                e = sb.pop_front();
                checks++; if (done !== 4'(1 << e.id) || res_acc1 !== e.acc1 || res_acc2 !== e.acc2 || res_flags !== e.flags) begin errors++;
                    $display("FAIL rr_result[%0d]: got=%b %h/%h/%b want=%b %h/%h/%b", nd, done, res_acc1, res_acc2, res_flags,
                             4'(1 << e.id), e.acc1, e.acc2, e.flags); end
                prev_done = cyc;
                nd++;
            end
        end
        checks++; if (nd != 6) begin errors++; $display("FAIL rr_count: got=%0d want=6", nd); end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        bit   issued = 0;
        int   stray = 0;
        mode = M_NEVER;
        set_req(3, 6'd1, 16'h0A0A, 16'h0B0B);
        for (int c = 0; c < 20 && !issued; c++) begin
            @(negedge clk);
            if (gnt !== '0) req = '0;
            if (alu_bgn === 1'b1) issued = 1;
        end
        repeat (3) @(negedge clk);
        checks++; if (!issued || busy !== 1'b1) begin errors++;
            $display("FAIL midop_inflight: got issued=%0b busy=%b want 1/1", issued, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({gnt, done, err, busy, alu_bgn} !== '0) begin errors++;
            $display("FAIL midop_ctrl: got=%b want=0", {gnt, done, err, busy, alu_bgn}); end
        checks++; if ({res_acc1, res_acc2, res_flags, res_id, alu_opcode, alu_a, alu_b} !== '0) begin errors++;
            $display("FAIL midop_data: got=%h want=0", {res_acc1, res_acc2, res_flags, res_id, alu_opcode, alu_a, alu_b}); end
        rst = 1'b0;
        last_acc1 = '0; last_acc2 = '0; last_flags = '0;
        repeat (MW + 4) begin
            @(negedge clk);
            if (done !== '0 || alu_bgn !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL midop_dropped: got=%0d stray cycles want=0", stray); end

        mode = M_NORMAL;
        set_req(0, 6'd1, 16'h0100, 16'h0023);
        set_req(3, 6'd1, 16'h0200, 16'h0045);
        push_exp(0, 16'h0100, 16'h0023, 0);
        step_until_done(30);
        req = '0;
        e = sb.pop_front();
        checks++; if (r_gnt !== 4'b0001) begin errors++; $display("FAIL midop_ptr: got=%b want=0001", r_gnt); end
        checks++; if (done !== 4'(1 << e.id) || res_acc1 !== e.acc1 || res_id !== e.id) begin errors++;
            $display("FAIL midop_next: got=%b acc=%h id=%0d want=%b acc=%h id=%0d", done, res_acc1, res_id, 4'(1 << e.id), e.acc1, e.id); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale_rdy();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_midop();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, got no finish want finish");
        $fatal(1);
    end

endmodule
